// File: rtl/lcd_line_scheduler.sv
// lcd_line_scheduler: owns the 8-bit HD44780 bus. It runs the power-up delay and
// the init command sequence, then arbitrates round-robin between two line
// streams (s0 -> line 1, s1 -> line 2). Each packet is preceded by a
// cursor-address command, and every byte goes through a setup/E-pulse/exec-wait
// engine.
module lcd_line_scheduler #(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned E_CYC     = 24,
  parameter int unsigned EXEC_CYC  = 2500,
  parameter int unsigned CLEAR_CYC = 100000,
  parameter int unsigned PWRUP_CYC = 1000000,
  parameter int unsigned CNT_W     = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {
    ST_PWRUP, ST_INIT, ST_IDLE, ST_ADDR, ST_STREAM, ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    EN_IDLE, EN_SETUP, EN_HIGH, EN_WAIT
  } eng_e;

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LD       = CNT_W'(E_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD    = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD   = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);

  state_e           state_q, state_d;
  eng_e             eng_q, eng_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [2:0]       init_idx_q, init_idx_d;
  logic             grant_q, grant_d;
  logic             rr_q, rr_d;
  logic [4:0]       chars_q, chars_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;
  logic             s0_ready_q, s0_ready_d;
  logic             s1_ready_q, s1_ready_d;
  logic             lcd_e_q, lcd_e_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [7:0]       lcd_data_q, lcd_data_d;

  logic             launch;
  logic             launch_rs;
  logic [7:0]       launch_data;
  logic             eng_ready;
  logic             eng_ready_nx;
  logic             hs;
  logic [7:0]       hs_data;
  logic             hs_last;
  logic [7:0]       init_cmd;

  // Top-level sequencing, byte engine and registered-output next-state logic.
  always_comb begin
    state_d     = state_q;
    eng_d       = eng_q;
    ecnt_d      = ecnt_q;
    pcnt_d      = pcnt_q;
    init_idx_d  = init_idx_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    chars_d     = chars_q;
    init_done_d = init_done_q;
    lcd_e_d     = lcd_e_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    launch      = 1'b0;
    launch_rs   = 1'b0;
    launch_data = '0;

    // The last wait cycle already counts as idle so back-to-back bytes are
    // spaced exactly SETUP+E+wait cycles apart.
    eng_ready = (eng_q == EN_IDLE) || ((eng_q == EN_WAIT) && (ecnt_q == '0));

    hs      = grant_q ? (s1_ready_q & s1_valid) : (s0_ready_q & s0_valid);
    hs_data = grant_q ? s1_data : s0_data;
    hs_last = grant_q ? s1_last : s0_last;

    case (init_idx_q)
      3'd0:    init_cmd = 8'h38;
      3'd1:    init_cmd = 8'h0C;
      3'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase

    case (state_q)
      ST_PWRUP: begin
        if (pcnt_q == PWRUP_LAST) state_d = ST_INIT;
        else                      pcnt_d  = pcnt_q + CNT_W'(1);
      end
      ST_INIT: begin
        if (eng_ready) begin
          if (init_idx_q == 3'd4) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            launch      = 1'b1;
            launch_data = init_cmd;
            init_idx_d  = init_idx_q + 3'd1;
          end
        end
      end
      ST_IDLE: begin
        if (s0_valid || s1_valid) begin
          grant_d = (s0_valid && s1_valid) ? rr_q : s1_valid;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (eng_ready) begin
          launch      = 1'b1;
          launch_data = grant_q ? 8'hC0 : 8'h80;
          chars_d     = '0;
          state_d     = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (hs) begin
          launch      = 1'b1;
          launch_rs   = 1'b1;
          launch_data = hs_data;
          chars_d     = chars_q + 5'd1;
          if (hs_last || (chars_q == 5'd15)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (eng_ready) begin
          rr_d    = ~grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_PWRUP;
    endcase

    case (eng_q)
      EN_SETUP: begin
        if (ecnt_q == '0) begin
          eng_d   = EN_HIGH;
          ecnt_d  = E_LD;
          lcd_e_d = 1'b1;
        end else begin
          ecnt_d = ecnt_q - CNT_W'(1);
        end
      end
      EN_HIGH: begin
        if (ecnt_q == '0) begin
          eng_d   = EN_WAIT;
          ecnt_d  = (!lcd_rs_q && (lcd_data_q == 8'h01)) ? CLEAR_LD : EXEC_LD;
          lcd_e_d = 1'b0;
        end else begin
          ecnt_d = ecnt_q - CNT_W'(1);
        end
      end
      EN_WAIT: begin
        if (ecnt_q == '0) eng_d  = EN_IDLE;
        else              ecnt_d = ecnt_q - CNT_W'(1);
      end
      default: ;
    endcase

    if (launch) begin
      eng_d      = EN_SETUP;
      ecnt_d     = SETUP_LD;
      lcd_rs_d   = launch_rs;
      lcd_data_d = launch_data;
    end

    // Ready is registered, so it is derived from the engine's next state:
    // a launch this cycle moves the engine to SETUP and drops ready.
    eng_ready_nx = (eng_d == EN_IDLE) || ((eng_d == EN_WAIT) && (ecnt_d == '0));
    s0_ready_d   = (state_d == ST_STREAM) && eng_ready_nx && !grant_d;
    s1_ready_d   = (state_d == ST_STREAM) && eng_ready_nx && grant_d;
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PWRUP;
      eng_q       <= EN_IDLE;
      ecnt_q      <= '0;
      pcnt_q      <= '0;
      init_idx_q  <= '0;
      grant_q     <= 1'b0;
      rr_q        <= 1'b0;
      chars_q     <= '0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      s0_ready_q  <= 1'b0;
      s1_ready_q  <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      eng_q       <= eng_d;
      ecnt_q      <= ecnt_d;
      pcnt_q      <= pcnt_d;
      init_idx_q  <= init_idx_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      chars_q     <= chars_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      s0_ready_q  <= s0_ready_d;
      s1_ready_q  <= s1_ready_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
    end
  end

  assign s0_ready  = s0_ready_q;
  assign s1_ready  = s1_ready_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;
  assign lcd_e     = lcd_e_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_line_scheduler.sv
// Directed bench for lcd_line_scheduler with short timing parameters.
module tb_lcd_line_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
  logic [7:0] s0_data = '0, s1_data = '0;
  logic       s0_ready, s1_ready, init_done, busy, lcd_e, lcd_rs;
  logic [7:0] lcd_data;

  lcd_line_scheduler #(
    .SETUP_CYC(2), .E_CYC(3), .EXEC_CYC(5), .CLEAR_CYC(12), .PWRUP_CYC(20), .CNT_W(21)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .init_done(init_done), .busy(busy),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Bus monitor: records {rs,data} at every lcd_e rise and counts ready pulses.
  logic [8:0] bus_q[$];
  logic [8:0] exp_q[$];
  int         r0_rises = 0, r1_rises = 0;
  logic       e_prev = 1'b0, r0_prev = 1'b0, r1_prev = 1'b0;

  always @(negedge clk) begin
    if (lcd_e && !e_prev)      bus_q.push_back({lcd_rs, lcd_data});
    if (s0_ready && !r0_prev)  r0_rises++;
    if (s1_ready && !r1_prev)  r1_rises++;
    e_prev  = lcd_e;
    r0_prev = s0_ready;
    r1_prev = s1_ready;
  end

  logic [7:0] s0_bytes[0:31];
  logic [7:0] s1_bytes[0:31];

  typedef struct {
    int         cyc;
    logic       e;
    logic       rs;
    logic [7:0] data;
    logic       done;
    logic       busy;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < NV; i++) begin
      while (cyc < tbl[i].cyc) @(negedge clk);
      chk($sformatf("%s_c%0d_e", tag, tbl[i].cyc),    lcd_e,     tbl[i].e);
      chk($sformatf("%s_c%0d_rs", tag, tbl[i].cyc),   lcd_rs,    tbl[i].rs);
      chk($sformatf("%s_c%0d_data", tag, tbl[i].cyc), lcd_data,  tbl[i].data);
      chk($sformatf("%s_c%0d_done", tag, tbl[i].cyc), init_done, tbl[i].done);
      chk($sformatf("%s_c%0d_busy", tag, tbl[i].cyc), busy,      tbl[i].busy);
      chk($sformatf("%s_c%0d_rdy", tag, tbl[i].cyc),  {s1_ready, s0_ready}, 2'b00);
    end
  endtask

  // Streams n bytes on one side; drops valid for gap_len cycles before byte
  // gap_after and counts cycles where the other side's ready was high then.
  task automatic send(input int side, input int n, input int last_idx,
                      input int gap_after, input int gap_len, output int viol);
    viol = 0;
    for (int i = 0; i < n; i++) begin
      int guard;
      if (gap_len > 0 && i == gap_after) begin
        if (side == 0) s0_valid = 1'b0; else s1_valid = 1'b0;
        repeat (gap_len) begin
          @(negedge clk);
          if ((side == 0) ? s1_ready : s0_ready) viol++;
        end
      end
      if (side == 0) begin
        s0_valid = 1'b1; s0_data = s0_bytes[i]; s0_last = (i == last_idx);
      end else begin
        s1_valid = 1'b1; s1_data = s1_bytes[i]; s1_last = (i == last_idx);
      end
      guard = 0;
      while (!((side == 0) ? s0_ready : s1_ready) && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) begin
        checks++; errors++;
        $display("FAIL send_timeout side %0d byte %0d: no ready within %0d cycles", side, i, guard);
      end
      @(negedge clk);
    end
    if (side == 0) begin s0_valid = 1'b0; s0_last = 1'b0; end
    else           begin s1_valid = 1'b0; s1_last = 1'b0; end
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    @(negedge clk);
    while (busy && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic chk_bus(input string name, input int mark);
    chk({name, "_len"}, bus_q.size() - mark, exp_q.size());
    for (int i = 0; i < exp_q.size() && (mark + i) < bus_q.size(); i++)
      chk($sformatf("%s_b%0d", name, i), bus_q[mark + i], exp_q[i]);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark, r0m, r1m, v0, v1, g;

    tbl[0]  = '{0,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{19, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[2]  = '{20, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[3]  = '{21, 1'b0, 1'b0, 8'h38, 1'b0, 1'b1};
    tbl[4]  = '{22, 1'b0, 1'b0, 8'h38, 1'b0, 1'b1};
    tbl[5]  = '{23, 1'b1, 1'b0, 8'h38, 1'b0, 1'b1};
    tbl[6]  = '{25, 1'b1, 1'b0, 8'h38, 1'b0, 1'b1};
    tbl[7]  = '{26, 1'b0, 1'b0, 8'h38, 1'b0, 1'b1};
    tbl[8]  = '{30, 1'b0, 1'b0, 8'h38, 1'b0, 1'b1};
    tbl[9]  = '{31, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b1};
    tbl[10] = '{33, 1'b1, 1'b0, 8'h0C, 1'b0, 1'b1};
    tbl[11] = '{36, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b1};
    tbl[12] = '{43, 1'b1, 1'b0, 8'h06, 1'b0, 1'b1};
    tbl[13] = '{46, 1'b0, 1'b0, 8'h06, 1'b0, 1'b1};
    tbl[14] = '{53, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[15] = '{55, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[16] = '{56, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[17] = '{67, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[18] = '{68, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};

    // Test 1: power-up and init timing.
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    run_table("init1");

    // Test 3a: both valid, pointer at s0 -> s0 packet first, then s1.
    s0_bytes[0] = 8'h31; s0_bytes[1] = 8'h32; s0_bytes[2] = 8'h33;
    s1_bytes[0] = 8'h41; s1_bytes[1] = 8'h42;
    @(negedge clk);
    mark = bus_q.size();
    fork
      send(0, 3, 2, -1, 0, v0);
      send(1, 2, 1, -1, 0, v1);
    join
    wait_idle("rr_a");
    exp_q = '{9'h080, 9'h131, 9'h132, 9'h133, 9'h0C0, 9'h141, 9'h142};
    chk_bus("rr_a", mark);

    // Test 2: "Park" on line 1.
    s0_bytes[0] = 8'h50; s0_bytes[1] = 8'h61; s0_bytes[2] = 8'h72; s0_bytes[3] = 8'h6B;
    mark = bus_q.size(); r0m = r0_rises; r1m = r1_rises;
    send(0, 4, 3, -1, 0, v0);
    wait_idle("park");
    exp_q = '{9'h080, 9'h150, 9'h161, 9'h172, 9'h16B};
    chk_bus("park", mark);
    chk("park_s0_ready_pulses", r0_rises - r0m, 4);
    chk("park_s1_ready_pulses", r1_rises - r1m, 0);

    // Test 3b: both valid after an s0 packet -> s1 served first.
    s0_bytes[0] = 8'h31; s0_bytes[1] = 8'h32; s0_bytes[2] = 8'h33;
    mark = bus_q.size();
    fork
      send(0, 3, 2, -1, 0, v0);
      send(1, 2, 1, -1, 0, v1);
    join
    wait_idle("rr_b");
    exp_q = '{9'h0C0, 9'h141, 9'h142, 9'h080, 9'h131, 9'h132, 9'h133};
    chk_bus("rr_b", mark);

    // Test 4a: 20 characters on s1 alone -> overflow at 16, re-addressed.
    for (int i = 0; i < 20; i++) s1_bytes[i] = 8'h41 + 8'(i);
    mark = bus_q.size();
    send(1, 20, 19, -1, 0, v1);
    wait_idle("ovf_a");
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'h41 + 8'(i)});
    exp_q.push_back(9'h0C0);
    for (int i = 16; i < 20; i++) exp_q.push_back({1'b1, 8'h41 + 8'(i)});
    chk_bus("ovf_a", mark);

    // Test 4b: overflow with s0 pending -> s0 served between the s1 halves.
    s0_bytes[0] = 8'h30; s0_bytes[1] = 8'h39;
    mark = bus_q.size();
    fork
      send(1, 20, 19, -1, 0, v1);
      begin
        repeat (30) @(negedge clk);
        send(0, 2, 1, -1, 0, v0);
      end
    join
    wait_idle("ovf_b");
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'h41 + 8'(i)});
    exp_q.push_back(9'h080); exp_q.push_back(9'h130); exp_q.push_back(9'h139);
    exp_q.push_back(9'h0C0);
    for (int i = 16; i < 20; i++) exp_q.push_back({1'b1, 8'h41 + 8'(i)});
    chk_bus("ovf_b", mark);

    // Test 5: s0 valid gap mid-packet keeps the grant; s1 waits.
    s0_bytes[0] = 8'h61; s0_bytes[1] = 8'h62; s0_bytes[2] = 8'h63; s0_bytes[3] = 8'h64;
    s1_bytes[0] = 8'h78; s1_bytes[1] = 8'h79;
    mark = bus_q.size();
    fork
      send(0, 4, 3, 2, 50, v0);
      send(1, 2, 1, -1, 0, v1);
    join
    wait_idle("gap");
    chk("gap_s1_ready_during_gap", v0, 0);
    exp_q = '{9'h080, 9'h161, 9'h162, 9'h163, 9'h164, 9'h0C0, 9'h178, 9'h179};
    chk_bus("gap", mark);

    // Test 6: reset while lcd_e is high during a character.
    mark = bus_q.size();
    s0_valid = 1'b1; s0_data = 8'h21; s0_last = 1'b1;
    g = 0;
    while (bus_q.size() < mark + 2 && g < 500) begin
      @(negedge clk); #1;
      g++;
    end
    chk("rst_pre_e", lcd_e, 1'b1);
    s0_data = 8'h5A;
    rst_n = 1'b0;
    #1;
    chk("rst_e",     lcd_e,     1'b0);
    chk("rst_rs",    lcd_rs,    1'b0);
    chk("rst_data",  lcd_data,  8'h00);
    chk("rst_ready", {s1_ready, s0_ready}, 2'b00);
    chk("rst_done",  init_done, 1'b0);
    chk("rst_busy",  busy,      1'b1);
    repeat (3) @(negedge clk);
    mark = bus_q.size();
    #2 rst_n = 1'b1;
    // s0 request held through PWRUP/INIT must not be accepted early.
    run_table("init2");
    g = 0;
    while (!s0_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("held_req_ready", s0_ready, 1'b1);
    @(negedge clk);
    s0_valid = 1'b0; s0_last = 1'b0;
    wait_idle("held");
    exp_q = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h080, 9'h15A};
    chk_bus("held", mark);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
